// File: rtl/verdict_collector.sv
// verdict_collector: buffers active monitor stream outputs as timestamped frames and serializes them as one record per active stream
module verdict_collector #(
  parameter int NUM_OUTPUTS = 10,
  parameter int DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 32,
  parameter int IDX_WIDTH   = $clog2(NUM_OUTPUTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_OUTPUTS-1:0]            out_aktv,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [IDX_WIDTH-1:0]              m_index,
  output logic [DATA_WIDTH-1:0]             m_value,
  output logic [TS_WIDTH-1:0]               m_timestamp,
  output logic                              m_last,
  output logic                              overflow,
  output logic [15:0]                       drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;
  state_e                            state_q, state_d;
  logic [TS_WIDTH-1:0]               ts_q, ts_d, wts_q, wts_d;
  logic [NUM_OUTPUTS-1:0]            mask_q, mask_d;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] vals_q, vals_d;
  logic [AW:0]                       wr_q, wr_d, rd_q, rd_d;
  logic                              overflow_q, overflow_d;
  logic [15:0]                       drop_q, drop_d;
  logic [TS_WIDTH-1:0]               f_ts_q   [FIFO_DEPTH];
  logic [NUM_OUTPUTS-1:0]            f_aktv_q [FIFO_DEPTH];
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] f_data_q [FIFO_DEPTH];
  logic                              empty, full, push, pop, hs;
  logic [IDX_WIDTH-1:0]              idx;
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign hs    = m_valid && m_ready && en;
  // Lowest set bit of the working mask selects the stream being emitted
  always_comb begin
    idx = '0;
    for (int i = NUM_OUTPUTS - 1; i >= 0; i--)
      if (mask_q[i]) idx = IDX_WIDTH'(i);
  end
  assign m_valid     = state_q == EMIT;
  assign m_index     = idx;
  assign m_value     = vals_q[idx*DATA_WIDTH +: DATA_WIDTH];
  assign m_timestamp = wts_q;
  assign m_last      = m_valid && (mask_q != '0) && ((mask_q & (mask_q - NUM_OUTPUTS'(1))) == '0);
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  // Next-state: capture/drop, then pop into the working frame when idle or when the last record is accepted
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    wts_d      = wts_q;
    mask_d     = mask_q;
    vals_d     = vals_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (en) begin
      ts_d = ts_q + TS_WIDTH'(1);
      if (out_aktv != '0) begin
        if (!full) begin
          push = 1'b1;
          wr_d = wr_q + (AW+1)'(1);
        end else begin
          overflow_d = 1'b1;
          drop_d     = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
        end
      end
      if (state_q == IDLE) begin
        pop = !empty;
      end else if (hs) begin
        if (!m_last) begin
          mask_d = mask_q & (mask_q - NUM_OUTPUTS'(1));
        end else if (empty) begin
          state_d = IDLE;
          mask_d  = '0;
        end else begin
          pop = 1'b1;
        end
      end
      if (pop) begin
        state_d = EMIT;
        mask_d  = f_aktv_q[rd_q[AW-1:0]];
        vals_d  = f_data_q[rd_q[AW-1:0]];
        wts_d   = f_ts_q[rd_q[AW-1:0]];
        rd_d    = rd_q + (AW+1)'(1);
      end
    end
  end
  // Control and working registers, cleared asynchronously so no partial record survives reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      wts_q      <= '0;
      mask_q     <= '0;
      vals_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      wts_q      <= wts_d;
      mask_q     <= mask_d;
      vals_q     <= vals_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end
  // Frame storage needs no reset: pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      f_ts_q[wr_q[AW-1:0]]   <= ts_q;
      f_aktv_q[wr_q[AW-1:0]] <= out_aktv;
      f_data_q[wr_q[AW-1:0]] <= out_data;
    end
  end
endmodule

// File: tb/tb_verdict_collector.sv
// tb_verdict_collector: randomized and directed checks of verdict_collector against a frame/record queue model
module tb_verdict_collector;
  localparam int N = 10, W = 64, D = 8, T = 32, I = 4;
  typedef struct {logic [I-1:0] idx; logic [W-1:0] val; logic [T-1:0] ts; logic last;} rec_t;
  typedef struct {logic [T-1:0] ts; logic [N-1:0] aktv; logic [N*W-1:0] data;} frm_t;
  logic clk = 1'b0, rst, en, m_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0] out_aktv;
  logic m_valid, m_last, overflow;
  logic [I-1:0] m_index;
  logic [W-1:0] m_value;
  logic [T-1:0] m_timestamp;
  logic [15:0] drop_count;
  int checks = 0, fails = 0;
  frm_t fifo[$];
  rec_t work[$];
  logic [T-1:0] mts;
  logic [15:0] mdrop;
  logic movf;

  verdict_collector dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_value(m_value),
    .m_timestamp(m_timestamp), .m_last(m_last), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    fifo.delete();
    work.delete();
    mts = '0;
    mdrop = '0;
    movf = 1'b0;
  endtask

  // One enabled edge: accept the presented record, refill from the queue, then capture or drop
  task automatic model_step();
    logic full;
    frm_t f;
    int c;
    if (!en) return;
    full = fifo.size() == D;
    if (work.size() > 0 && m_ready) void'(work.pop_front());
    if (work.size() == 0 && fifo.size() > 0) begin
      f = fifo.pop_front();
      c = 0;
      for (int i = 0; i < N; i++)
        if (f.aktv[i]) begin
          c++;
          work.push_back('{I'(i), f.data[i*W +: W], f.ts, c == $countones(f.aktv)});
        end
    end
    if (out_aktv != '0) begin
      if (!full) fifo.push_back('{mts, out_aktv, out_data});
      else begin
        movf = 1'b1;
        if (mdrop != 16'hFFFF) mdrop++;
      end
    end
    mts++;
  endtask

  function automatic logic [I+W+T:0] exp_rec();
    return (work.size() > 0) ? {work[0].idx, work[0].val, work[0].ts, work[0].last} : '0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; out_aktv = '0; out_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_valid, m_index, m_value, m_timestamp, m_last} !== '0) begin
      fails++;
      $display("FAIL reset_rec: got %h expected 0", {m_valid, m_index, m_value, m_timestamp, m_last});
    end
    checks++;
    if ({overflow, drop_count} !== 17'd0) begin
      fails++;
      $display("FAIL reset_ovf: got %b/%0d expected 0/0", overflow, drop_count);
    end
    rst = 1'b0;
    en = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    repeat (5) cyc();
    out_aktv = 10'b0000000101;
    out_data = '0;
    out_data[0 +: W] = 64'd7;
    out_data[2*W +: W] = 64'hFFFF_FFFF_FFFF_FFFD;
    m_ready = 1'b1;
    cyc();
    out_aktv = '0;
    checks++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_lat: got valid %b expected 0", m_valid);
    end
    cyc();
    checks++;
    if ({m_valid, m_index, m_value, m_timestamp, m_last} !== {1'b1, 4'd0, 64'd7, 32'd5, 1'b0}) begin
      fails++;
      $display("FAIL single_r0: got %b %0d %h %0d %b expected 1 0 7 5 0", m_valid, m_index, m_value, m_timestamp, m_last);
    end
    cyc();
    checks++;
    if ({m_valid, m_index, m_value, m_timestamp, m_last} !== {1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32'd5, 1'b1}) begin
      fails++;
      $display("FAIL single_r1: got %b %0d %h %0d %b expected 1 2 fffffffffffffffd 5 1", m_valid, m_index, m_value, m_timestamp, m_last);
    end
    cyc();
    checks++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_end: got valid %b expected 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [T-1:0] n;
    n = mts;
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      out_aktv = (k < 3) ? 10'b10 : '0;
      out_data = '0;
      out_data[W +: W] = 64'(k + 1);
      cyc();
      if (k >= 1 && k <= 3) begin
        checks++;
        if ({m_valid, m_index, m_value, m_timestamp, m_last} !== {1'b1, 4'd1, 64'(k), n + T'(k - 1), 1'b1}) begin
          fails++;
          $display("FAIL b2b_rec%0d: got %b %0d %0d %0d %b expected 1 1 %0d %0d 1", k, m_valid, m_index, m_value, m_timestamp, m_last, k, n + T'(k - 1));
        end
      end else if (k == 4) begin
        checks++;
        if (m_valid !== 1'b0) begin
          fails++;
          $display("FAIL b2b_end: got valid %b expected 0", m_valid);
        end
      end
    end
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      out_aktv = 10'b1000;
      out_data = '0;
      out_data[3*W +: W] = 64'(100 + k);
      cyc();
    end
    out_aktv = '0;
    checks++;
    if ({overflow, drop_count} !== {1'b1, 16'd1}) begin
      fails++;
      $display("FAIL ovf_flag: got %b/%0d expected 1/1", overflow, drop_count);
    end
    m_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      checks++;
      if ({m_valid, m_index, m_value, m_last} !== {1'b1, 4'd3, 64'(100 + j), 1'b1}) begin
        fails++;
        $display("FAIL ovf_rec%0d: got %b %0d %0d %b expected 1 3 %0d 1", j, m_valid, m_index, m_value, m_last, 100 + j);
      end
      cyc();
    end
    checks++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovf_end: got valid %b expected 0", m_valid);
    end
  endtask

  task automatic test_stall();
    logic [I+W+T+1:0] snap;
    logic stalled, fire;
    int acc;
    out_aktv = '1;
    for (int i = 0; i < N; i++) out_data[i*W +: W] = {$urandom, $urandom};
    m_ready = 1'b0;
    cyc();
    out_aktv = '0;
    acc = 0;
    for (int t = 0; t < 200 && acc < 10; t++) begin
      m_ready = 1'($urandom_range(0, 1));
      snap = {m_valid, m_index, m_value, m_timestamp, m_last};
      stalled = m_valid && !m_ready;
      fire = m_valid && m_ready;
      cyc();
      if (stalled) begin
        checks++;
        if ({m_valid, m_index, m_value, m_timestamp, m_last} !== snap) begin
          fails++;
          $display("FAIL stall_hold: got %h expected %h", {m_valid, m_index, m_value, m_timestamp, m_last}, snap);
        end
      end
      if (fire) begin
        checks++;
        if ({snap[I+W+T:W+T+1], snap[0]} !== {I'(acc), acc == 9}) begin
          fails++;
          $display("FAIL stall_order: got idx %0d last %b expected idx %0d last %b", snap[I+W+T:W+T+1], snap[0], acc, acc == 9);
        end
        acc++;
      end
      checks++;
      if (m_valid !== (work.size() > 0) || (m_valid && {m_index, m_value, m_timestamp, m_last} !== exp_rec())) begin
        fails++;
        $display("FAIL stall_model: got %b %h expected %b %h", m_valid, {m_index, m_value, m_timestamp, m_last}, work.size() > 0, exp_rec());
      end
    end
    checks++;
    if (acc != 10) begin
      fails++;
      $display("FAIL stall_count: got %0d records expected 10", acc);
    end
    cyc();
  endtask

  task automatic test_enable();
    out_aktv = 10'b11111;
    for (int i = 0; i < N; i++) out_data[i*W +: W] = {$urandom, $urandom};
    m_ready = 1'b1;
    cyc();
    out_aktv = '0;
    cyc();
    cyc();
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      out_aktv = (k == 1) ? 10'b1 : '0;
      cyc();
      checks++;
      if ({m_valid, m_index} !== {1'b1, 4'd1}) begin
        fails++;
        $display("FAIL en_freeze%0d: got %b %0d expected 1 1", k, m_valid, m_index);
      end
    end
    out_aktv = '0;
    en = 1'b1;
    cyc();
    checks++;
    if ({m_valid, m_index} !== {1'b1, 4'd2}) begin
      fails++;
      $display("FAIL en_resume: got %b %0d expected 1 2", m_valid, m_index);
    end
    for (int k = 0; k < 8; k++) begin
      out_aktv = (k == 4) ? 10'b100000 : '0;
      out_data[5*W +: W] = 64'(k);
      cyc();
      checks++;
      if (m_valid !== (work.size() > 0) || (m_valid && {m_index, m_value, m_timestamp, m_last} !== exp_rec())) begin
        fails++;
        $display("FAIL en_model: got %b %h expected %b %h", m_valid, {m_index, m_value, m_timestamp, m_last}, work.size() > 0, exp_rec());
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 500; t++) begin
      en = ($urandom_range(0, 9) != 0);
      out_aktv = ($urandom_range(0, 1) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++) out_data[i*W +: W] = {$urandom, $urandom};
      m_ready = (t < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc();
      checks++;
      if (m_valid !== (work.size() > 0) || (m_valid && {m_index, m_value, m_timestamp, m_last} !== exp_rec())) begin
        fails++;
        $display("FAIL rand_rec t=%0d: got %b %h expected %b %h", t, m_valid, {m_index, m_value, m_timestamp, m_last}, work.size() > 0, exp_rec());
      end
      checks++;
      if ({overflow, drop_count} !== {movf, mdrop}) begin
        fails++;
        $display("FAIL rand_drop t=%0d: got %b/%0d expected %b/%0d", t, overflow, drop_count, movf, mdrop);
      end
    end
    en = 1'b1;
    out_aktv = '0;
    m_ready = 1'b1;
    repeat (120) cyc();
    checks++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL rand_drain: got valid %b expected 0", m_valid);
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      out_aktv = N'($urandom_range(1, 1023));
      for (int i = 0; i < N; i++) out_data[i*W +: W] = {$urandom, $urandom};
      cyc();
    end
    out_aktv = '0;
    checks++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre: got valid %b expected 1", m_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_index, m_value, m_timestamp, m_last, overflow, drop_count} !== '0) begin
      fails++;
      $display("FAIL rmid_async: got %h expected 0", {m_valid, m_index, m_value, m_timestamp, m_last, overflow, drop_count});
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      checks++;
      if (m_valid !== 1'b0) begin
        fails++;
        $display("FAIL rmid_stale%0d: got valid %b expected 0", k, m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_enable();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
